mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between data access and fetch; one CPU step per round (3 cycles min, 4 with data).
// Memory wait states stall the CPU via memready; a missing ack aborts the request after TMO cycles and sets err.
module mem_arbiter #(
  parameter int N   = 64,
  parameter int TMO = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  instradr,
  output logic [31:0]  instr,
  input  logic [N-1:0] dataadr,
  input  logic [N-1:0] writedata,
  input  logic [1:0]   memwriteM,
  input  logic         memreadM,
  input  logic         dword,
  output logic [N-1:0] readdata,
  output logic         memready,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [1:0]   mem_we,
  output logic         mem_dword,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         err,
  output logic [31:0]  stall_cnt
);

  typedef enum logic [1:0] {ISSUE, DREQ, IREQ, READY} state_t;

  // The request is abandoned on the cycle that would make the TMO-th ack-less cycle.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t         state, state_nxt;
  logic [31:0]    hold_addr;
  logic [N-1:0]   hold_wdata;
  logic [1:0]     hold_we;
  logic           hold_rd;
  logic           hold_dword;
  logic [7:0]     wait_cnt;
  logic [31:0]    instr_q;
  logic [N-1:0]   readdata_q;
  logic           err_q;
  logic [31:0]    stall_q;
  logic           in_req;
  logic           tmo_hit;
  logic           req_entry;
  logic [N-1:0]   unused_dataadr;

  assign unused_dataadr = dataadr;

  assign in_req  = (state == DREQ) || (state == IREQ);
  // An ack in the same cycle as the timeout wins.
  assign tmo_hit = in_req && !mem_ack && (wait_cnt == TMO_LAST);
  assign req_entry = (state_nxt != state) && ((state_nxt == DREQ) || (state_nxt == IREQ));

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE:   state_nxt = ((memwriteM != 2'b00) || memreadM) ? DREQ : IREQ;
      DREQ: begin
        if (mem_ack)
          state_nxt = IREQ;
        else if (tmo_hit)
          state_nxt = READY;
      end
      IREQ: begin
        if (mem_ack || tmo_hit)
          state_nxt = READY;
      end
      READY:   state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = '0;
    mem_we    = 2'b00;
    mem_dword = 1'b0;
    memready  = reset || (state == READY);
    if (!reset) begin
      case (state)
        DREQ: begin
          mem_req   = 1'b1;
          mem_addr  = hold_addr;
          mem_wdata = hold_wdata;
          mem_we    = hold_we;
          mem_dword = hold_dword;
        end
        IREQ: begin
          mem_req  = 1'b1;
          mem_addr = instradr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ISSUE;
      hold_addr  <= 32'h0;
      hold_wdata <= '0;
      hold_we    <= 2'b00;
      hold_rd    <= 1'b0;
      hold_dword <= 1'b0;
      wait_cnt   <= 8'h0;
      instr_q    <= 32'h0;
      readdata_q <= '0;
      err_q      <= 1'b0;
      stall_q    <= 32'h0;
    end else begin
      state <= state_nxt;

      if (state == ISSUE) begin
        hold_addr  <= dataadr[31:0];
        hold_wdata <= writedata;
        hold_we    <= memwriteM;
        hold_rd    <= memreadM;
        hold_dword <= dword;
      end

      if (req_entry)
        wait_cnt <= 8'h0;
      else if (in_req && !mem_ack)
        wait_cnt <= wait_cnt + 8'd1;

      if ((state == DREQ) && mem_ack && hold_rd)
        readdata_q <= mem_rdata;
      if ((state == IREQ) && mem_ack)
        instr_q <= mem_rdata[31:0];

      // Aborted round returns a NOP so the CPU steps forward deterministically.
      if (tmo_hit) begin
        err_q   <= 1'b1;
        instr_q <= 32'h0;
        if ((state == DREQ) && hold_rd)
          readdata_q <= '0;
      end

      if ((state != READY) && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign instr     = instr_q;
  assign readdata  = readdata_q;
  assign err       = err_q;
  assign stall_cnt = stall_q;

endmodule
